// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deserializes
// 11-bit frames, strips F0/E0 prefixes, and reports one scan code per key event.
// Optional feature macro PS2_TIMEOUT_EN: abandons a stalled frame after TIMEOUT
// system-clock cycles without a filtered ps2_clk falling edge.
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [7:0] key_status
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // The filter counter and the timeout compare need sane parameter values.
    if (FILTER_LEN < 2 || TIMEOUT < 2) begin : g_param_check
        $error("ps2_keyboard_decoder: FILTER_LEN and TIMEOUT must be at least 2");
    end

    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        data_sync_q, data_sync_d;
    logic              filt_q, filt_d;
    logic              filt_prev_q, filt_prev_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              brk_pend_q, brk_pend_d;
    logic              ext_pend_q, ext_pend_d;
    logic [7:0]        keycode_q, keycode_d;
    logic              brk_q, brk_d;
    logic              ext_q, ext_d;
    logic              err_q, err_d;
    logic              strobe_q, strobe_d;

    logic clk_s;
    logic data_s;
    logic fall;
    logic frame_ok;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign fall     = filt_prev_q & ~filt_q;
    // Odd parity over data+parity, and the stop bit (sampled this edge) must be 1.
    assign frame_ok = (^{shift_q, parity_q}) & data_s;

    assign keycode    = keycode_q;
    assign key_status = {4'b0000, err_q, ext_q, strobe_q, brk_q};

    // Synchronizers and glitch filter: level flips after FILTER_LEN differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        fcnt_d      = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    // Input-side state registers, idle-high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            fcnt_q      <= fcnt_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;

    // Cycles since the last falling edge while a frame is in progress.
    always_comb begin
        to_cnt_d    = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TO_W'(1);
        timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_W'(TIMEOUT - 1));
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM, prefix tracking and output updates (visible the cycle after evaluation).
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        keycode_d  = keycode_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        err_d      = err_q;
        strobe_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && !data_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end else if (shift_q == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else begin
                        keycode_d  = shift_q;
                        brk_d      = brk_pend_q;
                        ext_d      = ext_pend_q;
                        err_d      = 1'b0;
                        strobe_d   = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d    = S_IDLE;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
            err_d      = 1'b1;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            keycode_q  <= 8'h00;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            keycode_q  <= keycode_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            err_q      <= err_d;
            strobe_q   <= strobe_d;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: table of byte sequences plus
// hand-written glitch, mid-frame reset and (optionally) timeout sequences.
module tb_ps2_keyboard_decoder;

    localparam int HALF = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic [7:0] key_status;

    int passed;
    int checks;

    int         strobes;
    logic [7:0] kc_at;
    logic [7:0] st_at;

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] bad;
        int         exp_strobes;
        logic [7:0] exp_kc;
        logic [7:0] exp_st_strobe;
        logic [7:0] exp_st_after;
    } vec_t;

    vec_t vecs[10];

    ps2_keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .key_status (key_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe cycle and what the outputs held in it.
    always @(negedge clk) begin
        if (key_status[1]) begin
            strobes <= strobes + 1;
            kc_at   <= keycode;
            st_at   <= key_status;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    initial begin
        int         s0;
        logic [7:0] bytes[3];
        passed   = 0;
        checks   = 0;
        strobes  = 0;
        kc_at    = 8'h00;
        st_at    = 8'h00;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;

        vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, 3'b000, 1, 8'h1C, 8'h02, 8'h00};
        vecs[1] = '{2, 8'hF0, 8'h1C, 8'h00, 3'b000, 1, 8'h1C, 8'h03, 8'h01};
        vecs[2] = '{3, 8'hE0, 8'hF0, 8'h75, 3'b000, 1, 8'h75, 8'h07, 8'h05};
        vecs[3] = '{1, 8'h1C, 8'h00, 8'h00, 3'b000, 1, 8'h1C, 8'h02, 8'h00};
        vecs[4] = '{1, 8'h1C, 8'h00, 8'h00, 3'b001, 0, 8'h1C, 8'h00, 8'h08};
        vecs[5] = '{1, 8'h32, 8'h00, 8'h00, 3'b000, 1, 8'h32, 8'h02, 8'h00};
        vecs[6] = '{3, 8'hF0, 8'hE0, 8'h5A, 3'b000, 1, 8'h5A, 8'h07, 8'h05};
        vecs[7] = '{3, 8'hF0, 8'hF0, 8'h1C, 3'b000, 1, 8'h1C, 8'h03, 8'h01};
        vecs[8] = '{2, 8'hE0, 8'h1C, 8'h00, 3'b010, 0, 8'h1C, 8'h00, 8'h09};
        vecs[9] = '{1, 8'h6B, 8'h00, 8'h00, 3'b000, 1, 8'h6B, 8'h02, 8'h00};

        wait_cyc(5);
        @(negedge clk);
        check("reset_keycode", 32'(keycode), 32'h00);
        check("reset_status", 32'(key_status), 32'h00);
        rst_n = 1'b1;
        wait_cyc(10);

        for (int v = 0; v < 10; v++) begin
            s0 = strobes;
            bytes[0] = vecs[v].b0;
            bytes[1] = vecs[v].b1;
            bytes[2] = vecs[v].b2;
            for (int k = 0; k < vecs[v].n; k++) send_frame(bytes[k], vecs[v].bad[k]);
            wait_cyc(10);
            @(negedge clk);
            check($sformatf("v%0d_strobes", v), 32'(strobes - s0), 32'(vecs[v].exp_strobes));
            check($sformatf("v%0d_keycode", v), 32'(keycode), 32'(vecs[v].exp_kc));
            if (vecs[v].exp_strobes > 0)
                check($sformatf("v%0d_status_strobe", v), 32'(st_at), 32'(vecs[v].exp_st_strobe));
            check($sformatf("v%0d_status_after", v), 32'(key_status), 32'(vecs[v].exp_st_after));
        end

        // Short low pulse on ps2_clk with data low must not start a frame.
        s0 = strobes;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(5);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HALF);
        send_frame(8'h4D, 1'b0);
        wait_cyc(10);
        @(negedge clk);
        check("glitch_strobes", 32'(strobes - s0), 32'd1);
        check("glitch_keycode", 32'(keycode), 32'h4D);
        check("glitch_status_strobe", 32'(st_at), 32'h02);

        // Reset after five data bits aborts the frame.
        s0 = strobes;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        check("midreset_keycode", 32'(keycode), 32'h00);
        check("midreset_status", 32'(key_status), 32'h00);
        rst_n    = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HALF);
        check("midreset_no_strobe", 32'(strobes - s0), 32'd0);
        send_frame(8'h29, 1'b0);
        wait_cyc(10);
        @(negedge clk);
        check("after_reset_strobes", 32'(strobes - s0), 32'd1);
        check("after_reset_keycode", 32'(keycode), 32'h29);
        check("after_reset_status_strobe", 32'(st_at), 32'h02);
        check("after_reset_status", 32'(key_status), 32'h00);

`ifdef PS2_TIMEOUT_EN
        // Clock stalls after four data bits; the frame is abandoned.
        s0 = strobes;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(150);
        @(negedge clk);
        check("timeout_no_strobe", 32'(strobes - s0), 32'd0);
        check("timeout_status", 32'(key_status), 32'h08);
        check("timeout_keycode", 32'(keycode), 32'h29);
        send_frame(8'h1C, 1'b0);
        wait_cyc(10);
        @(negedge clk);
        check("timeout_next_strobes", 32'(strobes - s0), 32'd1);
        check("timeout_next_keycode", 32'(keycode), 32'h1C);
        check("timeout_next_status", 32'(key_status), 32'h00);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_decoder.md
Name: ps2_keyboard_decoder

Overview:
- Receives the raw PS/2 keyboard serial stream (device-driven clock and data lines) and deserializes 11-bit frames.
- Strips F0 (break) and E0 (extended) prefix bytes and presents one completed scan code per key event.
- Outputs the keycode/key_status pair consumed by the READKEY instruction path, with a one-cycle "signal comes now" strobe per event.
- Sits between the board PS/2 pins and the core's keyboard read logic.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clk level changes
TIMEOUT, 50000, system-clock cycles without a filtered ps2_clk falling edge mid-frame before the frame is abandoned (used only with PS2_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
keycode  output  8  last completed scan code (prefixes removed)
key_status  output  8  bit0 is_break, bit1 signal_comes_now (1-cycle pulse), bit2 extended (E0 seen), bit3 frame_error, bits7:4 zero

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0, FSM is IDLE, break/extended pending flags are cleared, and synchronizers and filter are set to idle-high.
- ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- Filtered ps2_clk changes level only after FILTER_LEN consecutive equal synchronized samples.
- A falling edge is a filtered high-to-low transition, one cycle wide.
- Data is sampled only on a falling edge, using the synchronized ps2_data value in that cycle.
- FSM states:
  - IDLE: on falling edge with data=0, go to DATA with bit count 0. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on falling edge, evaluate the frame and go to IDLE.
- Frame validity: odd parity (8 data bits + parity bit has an odd number of 1s) and stop bit = 1.
- Frame evaluation happens in cycle N, the STOP falling-edge cycle. All resulting output updates appear in cycle N+1.
- Valid byte F0: set break_pending. No output change.
- Valid byte E0: set ext_pending. No output change.
- Any other valid byte:
  - keycode <= byte; bit0 <= break_pending; bit2 <= ext_pending; bit3 <= 0.
  - bit1 = 1 for exactly one cycle (N+1).
  - Both pending flags clear.
- Invalid frame:
  - Byte is discarded and both pending flags clear.
  - bit3 <= 1, held until the next emitted key event.
  - bit1 is not pulsed; keycode, bit0 and bit2 are unchanged.
- keycode, bit0 and bit2 hold their values between events.
- bit1 is 0 in every cycle except the single strobe cycle.
- Back-to-back frames are supported with no dead time beyond the filter delay.
- F0 F0 xx is treated as break.
- E0 F0 xx and F0 E0 xx both give break=1, extended=1.
- The block never drives the PS/2 lines (receive only; host-to-device commands are out of scope).
- Reset asserted mid-frame aborts the frame. The partial byte never produces a strobe.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while the FSM is not in IDLE and reloads on every falling edge.
  - When it reaches TIMEOUT, the FSM returns to IDLE, pending flags clear, and bit3 is set. No strobe is issued.
  - This recovers from glitches and from keyboard hot-plug mid-frame.
- Not defined:
  - No counter logic exists, and TIMEOUT is unused.
  - A partial frame waits indefinitely for its remaining edges.

Test Plan:
- Make code 0x1C, frame 0,00111000,parity 0,stop 1 (FILTER_LEN=8) -> one strobe; keycode=0x1C, key_status=0x02 in strobe cycle, then 0x00.
- Break sequence F0 1C -> no strobe after F0; single strobe after 1C; keycode=0x1C, key_status=0x03 in strobe cycle, then 0x01.
- Extended break E0 F0 75 -> single strobe; keycode=0x75, key_status=0x07 in strobe cycle; a following plain 0x1C gives key_status=0x02.
- Bad parity on 0x1C, then good 0x32 -> no strobe for first frame and key_status=0x08; after 0x32 keycode=0x32, key_status=0x02 then 0x00.
- Glitch: ps2_clk low pulse shorter than FILTER_LEN cycles while in IDLE -> no state change; rst_n pulsed low after 5 data bits -> all outputs 0, next full frame 0x29 decodes correctly.
- With PS2_TIMEOUT_EN, TIMEOUT=100: stop ps2_clk after 4 data bits for 150 cycles -> FSM back to IDLE, bit3=1, no strobe; next frame 0x1C decodes normally.
